// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multicycle MIPS-subset CPU.
// Sequences fetch/decode/execute/memory/writeback and guards memory waits with a watchdog.
`default_nettype none

module multicycle_control #(
    parameter int timeout_cycles = 255,
    parameter int cnt_width      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    input  logic       alu_zero,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       LUI,
    output logic [1:0] MemtoReg,
    output logic [3:0] state,
    output logic       illegal_op,
    output logic       mem_timeout
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_RWB    = 4'd7,
        S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_ADDIEX = 4'd10, S_IWB    = 4'd11,
        S_LUIWB  = 4'd12
    } state_t;

    state_t                 cur, nxt;
    logic [cnt_width-1:0]   cnt, cnt_nxt;
    logic                   wait_st, expired;
    logic                   unused_zero;

    // alu_zero is consumed by the datapath together with PCWriteCond.
    assign unused_zero = alu_zero;

    assign wait_st = (cur == S_FETCH) || (cur == S_MEMRD) || (cur == S_MEMWR);
    assign expired = wait_st && !mem_ready && (cnt == cnt_width'(timeout_cycles));
    assign cnt_nxt = (wait_st && !mem_ready && !expired) ? cnt + cnt_width'(1) : '0;
    assign state   = cur;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= S_FETCH;
            cnt <= '0;
        end else begin
            cur <= nxt;
            cnt <= cnt_nxt;
        end
    end

    always_comb begin
        nxt         = cur;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        LUI         = 1'b0;
        MemtoReg    = 2'b00;
        illegal_op  = 1'b0;
        mem_timeout = 1'b0;
        case (cur)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    nxt     = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    6'b000000:            nxt = S_EXEC;
                    6'b100011, 6'b101011: nxt = S_MEMADR;
                    6'b000100:            nxt = S_BRANCH;
                    6'b000010:            nxt = S_JUMP;
                    6'b001000:            nxt = S_ADDIEX;
                    6'b001111:            nxt = S_LUIWB;
                    default: begin
                        illegal_op = 1'b1;
                        nxt        = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                nxt     = (opcode == 6'b100011) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) nxt = S_MEMWB;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b01;
                nxt      = S_FETCH;
            end
            S_MEMWR: begin
                // An aborted store must not leave a write strobe on the bus.
                MemWrite = !expired;
                IorD     = 1'b1;
                if (mem_ready) nxt = S_FETCH;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                nxt     = S_RWB;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                nxt      = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                nxt         = S_FETCH;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                nxt      = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                nxt     = S_IWB;
            end
            S_IWB: begin
                RegWrite = 1'b1;
                nxt      = S_FETCH;
            end
            S_LUIWB: begin
                RegWrite = 1'b1;
                LUI      = 1'b1;
                MemtoReg = 2'b10;
                nxt      = S_FETCH;
            end
            default: nxt = S_FETCH;
        endcase
        if (expired) begin
            mem_timeout = 1'b1;
            nxt         = S_FETCH;
        end
        if (rst) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            PCSource    = 2'b00;
            ALUOp       = 2'b00;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            RegWrite    = 1'b0;
            RegDst      = 1'b0;
            LUI         = 1'b0;
            MemtoReg    = 2'b00;
            illegal_op  = 1'b0;
            mem_timeout = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench for the multicycle control FSM.
`default_nettype none

module tb_multicycle_control;

    typedef struct packed {
        logic       PCWrite;
        logic       PCWriteCond;
        logic       IorD;
        logic       MemRead;
        logic       MemWrite;
        logic       IRWrite;
        logic [1:0] PCSource;
        logic [1:0] ALUOp;
        logic       ALUSrcA;
        logic [1:0] ALUSrcB;
        logic       RegWrite;
        logic       RegDst;
        logic       LUI;
        logic [1:0] MemtoReg;
        logic       illegal_op;
        logic       mem_timeout;
    } ctl_t;

    typedef struct {
        string      tag;
        logic [3:0] st;
        ctl_t       ctl;
    } exp_t;

    logic       clk, rst, mem_ready, alu_zero;
    logic [5:0] opcode;
    logic [3:0] state;
    ctl_t       got;
    exp_t       sb[$];
    int         checks = 0;
    int         failures = 0;

    multicycle_control #(.timeout_cycles(4), .cnt_width(8)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .alu_zero(alu_zero),
        .PCWrite(got.PCWrite), .PCWriteCond(got.PCWriteCond), .IorD(got.IorD),
        .MemRead(got.MemRead), .MemWrite(got.MemWrite), .IRWrite(got.IRWrite),
        .PCSource(got.PCSource), .ALUOp(got.ALUOp), .ALUSrcA(got.ALUSrcA),
        .ALUSrcB(got.ALUSrcB), .RegWrite(got.RegWrite), .RegDst(got.RegDst),
        .LUI(got.LUI), .MemtoReg(got.MemtoReg), .state(state),
        .illegal_op(got.illegal_op), .mem_timeout(got.mem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Per-state control values, without the handshake-dependent bits.
    function automatic ctl_t base(input logic [3:0] st);
        ctl_t c = '0;
        case (st)
            4'd0:  begin c.MemRead = 1'b1; c.ALUSrcB = 2'b01; end
            4'd1:  c.ALUSrcB = 2'b11;
            4'd2:  begin c.ALUSrcA = 1'b1; c.ALUSrcB = 2'b10; end
            4'd3:  begin c.MemRead = 1'b1; c.IorD = 1'b1; end
            4'd4:  begin c.RegWrite = 1'b1; c.MemtoReg = 2'b01; end
            4'd5:  begin c.MemWrite = 1'b1; c.IorD = 1'b1; end
            4'd6:  begin c.ALUSrcA = 1'b1; c.ALUOp = 2'b10; end
            4'd7:  begin c.RegWrite = 1'b1; c.RegDst = 1'b1; end
            4'd8:  begin c.ALUSrcA = 1'b1; c.ALUOp = 2'b01; c.PCWriteCond = 1'b1; c.PCSource = 2'b01; end
            4'd9:  begin c.PCWrite = 1'b1; c.PCSource = 2'b10; end
            4'd10: begin c.ALUSrcA = 1'b1; c.ALUSrcB = 2'b10; end
            4'd11: c.RegWrite = 1'b1;
            4'd12: begin c.RegWrite = 1'b1; c.LUI = 1'b1; c.MemtoReg = 2'b10; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic ctl_t fetch_ok();
        ctl_t c = base(4'd0);
        c.IRWrite = 1'b1;
        c.PCWrite = 1'b1;
        return c;
    endfunction

    // Drive one cycle of stimulus and queue what the DUT must show in it.
    task automatic step(input string tag, input logic [5:0] opc, input logic rdy,
                        input logic [3:0] st, input ctl_t c);
        exp_t e;
        opcode    = opc;
        mem_ready = rdy;
        e.tag = tag; e.st = st; e.ctl = c;
        sb.push_back(e);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, "_st"}, 32'(state), 32'(e.st));
            chk({e.tag, "_ctl"}, 32'(got), 32'(e.ctl));
        end
    end

    initial begin
        ctl_t c;
        rst = 1'b1; opcode = 6'd0; mem_ready = 1'b0; alu_zero = 1'b0;
        #3;
        mem_ready = 1'b1;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ctl", 32'(got), 32'd0);
        mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // fetch with two wait states, then R-type
        step("fw0", 6'd0, 1'b0, 4'd0, base(4'd0));
        step("fw1", 6'd0, 1'b0, 4'd0, base(4'd0));
        step("r_f", 6'd0, 1'b1, 4'd0, fetch_ok());
        step("r_d", 6'b000000, 1'b1, 4'd1, base(4'd1));
        step("r_ex", 6'b000000, 1'b1, 4'd6, base(4'd6));
        step("r_wb", 6'b000000, 1'b1, 4'd7, base(4'd7));

        // lw with three wait cycles
        step("lw_f", 6'b100011, 1'b1, 4'd0, fetch_ok());
        step("lw_d", 6'b100011, 1'b1, 4'd1, base(4'd1));
        step("lw_a", 6'b100011, 1'b1, 4'd2, base(4'd2));
        for (int i = 0; i < 3; i++) step("lw_w", 6'b100011, 1'b0, 4'd3, base(4'd3));
        step("lw_rd", 6'b100011, 1'b1, 4'd3, base(4'd3));
        step("lw_wb", 6'b100011, 1'b1, 4'd4, base(4'd4));

        // lw whose ready lands exactly on the timeout count: success
        step("lb_f", 6'b100011, 1'b1, 4'd0, fetch_ok());
        step("lb_d", 6'b100011, 1'b1, 4'd1, base(4'd1));
        step("lb_a", 6'b100011, 1'b1, 4'd2, base(4'd2));
        for (int i = 0; i < 4; i++) step("lb_w", 6'b100011, 1'b0, 4'd3, base(4'd3));
        step("lb_rd", 6'b100011, 1'b1, 4'd3, base(4'd3));
        step("lb_wb", 6'b100011, 1'b1, 4'd4, base(4'd4));

        // sw, zero wait
        step("sw_f", 6'b101011, 1'b1, 4'd0, fetch_ok());
        step("sw_d", 6'b101011, 1'b1, 4'd1, base(4'd1));
        step("sw_a", 6'b101011, 1'b1, 4'd2, base(4'd2));
        step("sw_wr", 6'b101011, 1'b1, 4'd5, base(4'd5));

        // sw that times out
        step("st_f", 6'b101011, 1'b1, 4'd0, fetch_ok());
        step("st_d", 6'b101011, 1'b1, 4'd1, base(4'd1));
        step("st_a", 6'b101011, 1'b1, 4'd2, base(4'd2));
        for (int i = 0; i < 4; i++) step("st_w", 6'b101011, 1'b0, 4'd5, base(4'd5));
        c = base(4'd5);
        c.MemWrite = 1'b0;
        c.mem_timeout = 1'b1;
        step("st_to", 6'b101011, 1'b0, 4'd5, c);

        // beq, j, addi, lui
        step("bq_f", 6'b000100, 1'b1, 4'd0, fetch_ok());
        step("bq_d", 6'b000100, 1'b1, 4'd1, base(4'd1));
        step("bq_b", 6'b000100, 1'b1, 4'd8, base(4'd8));
        step("j_f", 6'b000010, 1'b1, 4'd0, fetch_ok());
        step("j_d", 6'b000010, 1'b1, 4'd1, base(4'd1));
        step("j_j", 6'b000010, 1'b1, 4'd9, base(4'd9));
        step("ai_f", 6'b001000, 1'b1, 4'd0, fetch_ok());
        step("ai_d", 6'b001000, 1'b1, 4'd1, base(4'd1));
        step("ai_ex", 6'b001000, 1'b1, 4'd10, base(4'd10));
        step("ai_wb", 6'b001000, 1'b1, 4'd11, base(4'd11));
        step("lu_f", 6'b001111, 1'b1, 4'd0, fetch_ok());
        step("lu_d", 6'b001111, 1'b1, 4'd1, base(4'd1));
        step("lu_wb", 6'b001111, 1'b1, 4'd12, base(4'd12));

        // illegal opcode
        step("il_f", 6'b111111, 1'b1, 4'd0, fetch_ok());
        c = base(4'd1);
        c.illegal_op = 1'b1;
        step("il_d", 6'b111111, 1'b1, 4'd1, c);
        step("il_nx", 6'b111111, 1'b0, 4'd0, base(4'd0));

        // asynchronous reset in the middle of MEMRD
        step("ar_f", 6'b100011, 1'b1, 4'd0, fetch_ok());
        step("ar_d", 6'b100011, 1'b1, 4'd1, base(4'd1));
        step("ar_a", 6'b100011, 1'b0, 4'd2, base(4'd2));
        step("ar_w", 6'b100011, 1'b0, 4'd3, base(4'd3));
        #2;
        rst = 1'b1;
        #1;
        chk("ar_rst_state", 32'(state), 32'd0);
        chk("ar_rst_ctl", 32'(got), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        step("ar_fetch", 6'd0, 1'b0, 4'd0, base(4'd0));
        step("ar_go", 6'd0, 1'b1, 4'd0, fetch_ok());

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
